// File: rtl/psk8_symbol_mapper.sv
// 8-PSK symbol mapper.
// Collects serial bits into 3-bit groups (first bit is the MSB) and optionally
// Gray-decodes each group to a phase index. Each phase index is held on
// phase_offset for SYM_PERIOD clocks. One pending register decouples the bit
// assembler from the symbol timer. When the timer expires with no pending
// symbol, the block drops to IDLE_PHASE and sets a sticky underrun flag.
module psk8_symbol_mapper #(
  parameter int unsigned SYM_PERIOD = 100,
  parameter bit          GRAY_EN    = 1'b1,
  parameter logic [2:0]  IDLE_PHASE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [2:0] phase_offset,
  output logic       sym_strobe,
  output logic       active,
  output logic       underrun
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Last hold count of a symbol; the hold counter runs 0..SYM_PERIOD-1.
  localparam logic [15:0] HOLD_LAST = 16'(SYM_PERIOD - 1);

  // Gray decode: each phase bit is the XOR of the symbol bits at and above it.
  function automatic logic [2:0] map_symbol(input logic [2:0] sym);
    logic [2:0] ph;
    if (GRAY_EN) begin
      ph = {sym[2], sym[2] ^ sym[1], sym[2] ^ sym[1] ^ sym[0]};
    end else begin
      ph = sym;
    end
    return ph;
  endfunction

  state_t      state_q,      state_d;
  logic [15:0] hcnt_q,       hcnt_d;
  logic [1:0]  bit_cnt_q,    bit_cnt_d;
  logic [1:0]  sr_q,         sr_d;
  logic [2:0]  pend_q,       pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [2:0]  phase_q,      phase_d;
  logic        strobe_q,     strobe_d;
  logic        active_q,     active_d;
  logic        underrun_q,   underrun_d;
  logic        accept_s;

  // Ready depends only on registered state. A third bit can only be accepted
  // while the pending slot is empty.
  assign bit_ready = (bit_cnt_q != 2'd2) || !pend_valid_q;
  assign accept_s  = bit_valid && bit_ready;

  assign phase_offset = phase_q;
  assign sym_strobe   = strobe_q;
  assign active       = active_q;
  assign underrun     = underrun_q;

  // Next-state logic for the bit assembler, pending slot and symbol-hold FSM.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    phase_d      = phase_q;
    strobe_d     = 1'b0;
    active_d     = active_q;
    underrun_d   = underrun_q;

    // Assembler: shift in at the LSB. The third bit completes a group and
    // fills the pending slot. A partial group waits indefinitely.
    if (accept_s) begin
      sr_d = {sr_q[0], bit_in};
      if (bit_cnt_q == 2'd2) begin
        bit_cnt_d    = 2'd0;
        pend_d       = {sr_q, bit_in};
        pend_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 2'd1;
      end
    end else begin
      sr_d = sr_q;
    end

    // Symbol timer. A consume only happens while pend_valid_q is set, and a
    // pending write only while it is clear, so the two never collide.
    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          phase_d      = map_symbol(pend_q);
          pend_valid_d = 1'b0;
          hcnt_d       = 16'd0;
          strobe_d     = 1'b1;
          active_d     = 1'b1;
          state_d      = ST_RUN;
        end else begin
          phase_d  = IDLE_PHASE;
          active_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (hcnt_q == HOLD_LAST) begin
          hcnt_d = 16'd0;
          if (pend_valid_q) begin
            phase_d      = map_symbol(pend_q);
            pend_valid_d = 1'b0;
            strobe_d     = 1'b1;
          end else begin
            phase_d    = IDLE_PHASE;
            active_d   = 1'b0;
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      default: begin
        phase_d  = IDLE_PHASE;
        active_d = 1'b0;
        hcnt_d   = 16'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset. Reset discards held, pending and
  // partial data without issuing a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= 16'd0;
      bit_cnt_q    <= 2'd0;
      sr_q         <= 2'd0;
      pend_q       <= 3'd0;
      pend_valid_q <= 1'b0;
      phase_q      <= IDLE_PHASE;
      strobe_q     <= 1'b0;
      active_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      phase_q      <= phase_d;
      strobe_q     <= strobe_d;
      active_q     <= active_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_psk8_symbol_mapper.sv
// Scoreboard bench for psk8_symbol_mapper.
// The driver pushes the expected phase of every completed 3-bit group into a
// queue. A negedge monitor pops that queue on each strobe, and it also checks
// the hold length, the idle phase and the sticky underrun flag.
module tb_psk8_symbol_mapper;

  localparam int         P       = 4;
  localparam logic [2:0] IDLE_PH = 3'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic [2:0] phase_offset;
  logic       sym_strobe;
  logic       active;
  logic       underrun;

  logic       bit_in2 = 1'b0;
  logic       bit_valid2 = 1'b0;
  logic       bit_ready2;
  logic [2:0] phase2;
  logic       strobe2;
  logic       active2;
  logic       underrun2;

  psk8_symbol_mapper #(.SYM_PERIOD(P), .GRAY_EN(1'b1), .IDLE_PHASE(IDLE_PH)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .phase_offset(phase_offset), .sym_strobe(sym_strobe),
    .active(active), .underrun(underrun)
  );

  psk8_symbol_mapper #(.SYM_PERIOD(P), .GRAY_EN(1'b0), .IDLE_PHASE(3'd6)) dut_bin (
    .clk(clk), .rst(rst), .bit_in(bit_in2), .bit_valid(bit_valid2),
    .bit_ready(bit_ready2), .phase_offset(phase2), .sym_strobe(strobe2),
    .active(active2), .underrun(underrun2)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         stall_cnt = 0;
  logic [2:0] exp_q[$];
  bit         bits_q[$];
  logic       rst_s = 1'b0;

  always @(posedge clk) rst_s <= rst;

  // Reference mapping taken from the phase table: symbol value -> phase index.
  function automatic logic [2:0] ref_phase(input bit a, input bit b, input bit c);
    int tab [8];
    int s;
    tab = '{0, 1, 3, 2, 7, 6, 4, 5};
    s = (a ? 4 : 0) + (b ? 2 : 0) + (c ? 1 : 0);
    return 3'(tab[s]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: scoreboard pop on strobe, plus timing and flag checks each cycle.
  initial begin : monitor
    int         hold_cnt;
    bit         prev_active;
    logic [2:0] prev_phase;
    logic [2:0] e;
    bit         exp_underrun;
    hold_cnt = 0; prev_active = 0; prev_phase = 3'd0; exp_underrun = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        exp_q.delete();
        hold_cnt = 0; prev_active = 0; exp_underrun = 0;
        check("rst_phase", phase_offset, IDLE_PH);
        check("rst_strobe", sym_strobe, 0);
        check("rst_active", active, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", bit_ready, 1);
      end else begin
        if (sym_strobe) begin
          check("strobe_active", active, 1);
          if (prev_active) check("hold_len", hold_cnt, P);
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL strobe_unexpected: got phase %0d, expected no strobe", phase_offset);
          end else begin
            e = exp_q.pop_front();
            check("phase", phase_offset, e);
          end
          hold_cnt = 1; prev_active = 1; prev_phase = phase_offset;
        end else if (active) begin
          hold_cnt++;
          check("strobe_missing", prev_active, 1);
          check("phase_hold", phase_offset, prev_phase);
        end else begin
          if (prev_active) begin
            check("hold_len_last", hold_cnt, P);
            exp_underrun = 1;
          end
          check("idle_phase", phase_offset, IDLE_PH);
          prev_active = 0;
        end
        check("underrun", underrun, exp_underrun);
      end
    end
  end

  // One cycle of drive; records accepted bits and completed groups.
  task automatic send_bit(input bit b, input bit v, output bit acc);
    bit_in = b;
    bit_valid = v;
    @(negedge clk);
    acc = v && (bit_ready === 1'b1);
    if (v && !acc) stall_cnt++;
    if (acc) begin
      bits_q.push_back(b);
      if (bits_q.size() == 3) begin
        exp_q.push_back(ref_phase(bits_q[0], bits_q[1], bits_q[2]));
        bits_q.delete();
      end
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic push_bit(input bit b);
    bit acc;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 100) begin
      send_bit(b, 1'b1, acc);
      tries++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", tries);
    end
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b0;
    bits_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || active !== 1'b0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 1000) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d symbols still queued, expected 0", exp_q.size());
    end
    idle_cycles(2);
  endtask

  initial begin : driver
    bit sym_bits [24];
    bit acc;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Natural-binary instance: custom idle phase, then 1,0,0 -> 4.
    check("bin_idle_phase", phase2, 6);
    check("bin_ready", bit_ready2, 1);
    bit_in2 = 1'b1; bit_valid2 = 1'b1; @(posedge clk); #1;
    bit_in2 = 1'b0; @(posedge clk); #1;
    bit_in2 = 1'b0; @(posedge clk); #1;
    bit_valid2 = 1'b0;
    @(posedge clk); #1;
    check("bin_phase", phase2, 4);
    check("bin_strobe", strobe2, 1);
    check("bin_active", active2, 1);
    check("bin_underrun", underrun2, 0);

    // Single group 0,1,1: latency, phase 2, then underrun.
    push_bit(0); push_bit(1); push_bit(1);
    check("latency_early_active", active, 0);
    check("latency_early_strobe", sym_strobe, 0);
    @(posedge clk); #1;
    check("latency_strobe", sym_strobe, 1);
    check("latency_phase", phase_offset, 2);
    check("latency_active", active, 1);
    drain();
    check("single_underrun", underrun, 1);

    // Full-rate stream of the eight Gray codes -> phases 0..7 back to back.
    do_reset();
    sym_bits = '{0,0,0, 0,0,1, 0,1,1, 0,1,0, 1,1,0, 1,1,1, 1,0,1, 1,0,0};
    for (int i = 0; i < 24; i++) push_bit(sym_bits[i]);
    check("stream_no_gap", underrun, 0);
    drain();

    // Backpressure: a sustained stream must stall bit_ready without losing bits.
    do_reset();
    stall_cnt = 0;
    for (int i = 0; i < 15; i++) push_bit(1'($urandom_range(0, 1)));
    check("backpressure_seen", (stall_cnt > 0) ? 1 : 0, 1);
    drain();

    // Reset mid-symbol with a partial group, then 1,1,1 -> 5.
    do_reset();
    push_bit(1); push_bit(0); push_bit(1);
    idle_cycles(1);
    push_bit(0);
    do_reset();
    push_bit(1); push_bit(1); push_bit(1);
    @(posedge clk); #1;
    check("post_rst_phase", phase_offset, 5);
    check("post_rst_strobe", sym_strobe, 1);
    drain();

    // Random bits with random gaps, including underruns and idle restarts.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 12));
      push_bit(1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psk8_symbol_mapper.md
PSK8_SYMBOL_MAPPER -- requirements
Module: psk8_symbol_mapper

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter SYM_PERIOD, default 100: clocks each symbol is held; legal range 2..65535.
REQ-003 Parameter GRAY_EN, default 1: 1 = Gray-decode symbols to phase index, 0 = pass natural binary.
REQ-004 Parameter IDLE_PHASE, default 3'd0: phase driven when no symbol is active.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 bit_in  input  1  serial data bit, first bit of each group is symbol MSB.
REQ-008 bit_valid  input  1  bit_in is valid this cycle.
REQ-009 bit_ready  output  1  block accepts bit_in this cycle.
REQ-010 phase_offset  output  3  8-PSK phase index (units of 45 deg) driven to the DDS phase input.
REQ-011 sym_strobe  output  1  one-cycle pulse in the first cycle a new phase_offset is driven.
REQ-012 active  output  1  high while a symbol is being held (state RUN).
REQ-013 underrun  output  1  sticky flag, set when a symbol period ends with no pending symbol.

Function
REQ-014 A bit SHALL be accepted on a rising edge where bit_valid and bit_ready are both high; no other edge changes the assembler.
REQ-015 Assembler: 2-bit shift register plus bit count 0..2; each accepted bit shifts in at LSB; count increments, 2->0 on the third bit.
REQ-016 The third accepted bit SHALL write {sr[1],sr[0],bit_in} to a single pending register and set pend_valid at that edge.
REQ-017 bit_ready SHALL be (bit_cnt != 2) OR (pend_valid == 0), registered-state only, no combinational path from bit_valid.
REQ-018 Mapping, GRAY_EN=1: p2=s2, p1=s2^s1, p0=s2^s1^s0 (000->0, 001->1, 011->2, 010->3, 110->4, 111->5, 101->6, 100->7); GRAY_EN=0: p=s.
REQ-019 FSM states IDLE and RUN; 16-bit hold counter hcnt.
REQ-020 IDLE: phase_offset = IDLE_PHASE, active=0; at an edge with pend_valid=1: load mapped pending into phase_offset, clear pend_valid, hcnt<=0, sym_strobe<=1, go RUN.
REQ-021 RUN: hcnt increments each cycle; at the edge where hcnt == SYM_PERIOD-1: if pend_valid, load next symbol, clear pend_valid, hcnt<=0, sym_strobe<=1, stay RUN; else go IDLE, phase_offset<=IDLE_PHASE, underrun<=1.
REQ-022 Each symbol SHALL be driven for exactly SYM_PERIOD consecutive cycles when data keeps up; back-to-back symbols have no gap cycle.
REQ-023 Latency: third bit accepted at edge k with block in IDLE -> new phase_offset and sym_strobe visible after edge k+1.
REQ-024 Pending write and pending consume SHALL never coincide (guaranteed by REQ-017); a pending consume frees bit_ready from the next cycle.
REQ-025 sym_strobe SHALL be high for exactly one cycle per loaded symbol and low otherwise.
REQ-026 underrun SHALL stay set until rst; it does not stop operation, next pending symbol restarts RUN from IDLE.
REQ-027 Partial groups (count 1 or 2) SHALL be held indefinitely, never timed out or dropped.

Reset
REQ-028 On rst high at an edge: state IDLE, hcnt=0, bit_cnt=0, shift reg=0, pend_valid=0, phase_offset=IDLE_PHASE, sym_strobe=0, active=0, underrun=0; bit_ready=1 the following cycle.
REQ-029 rst asserted mid-symbol or mid-group SHALL discard held, pending and partial data with no strobe issued.

Verification
REQ-030 SYM_PERIOD=4, GRAY_EN=1: bits 0,1,1 with valid every cycle -> one cycle after third bit, phase_offset=2, sym_strobe pulses once, active=1, held 4 cycles then IDLE_PHASE and underrun=1.
REQ-031 Continuous stream 000,001,011,010,110,111,101,100 at full rate -> phase_offset sequence 0..7, each held exactly 4 cycles, no gaps, underrun stays 0.
REQ-032 Backpressure: 6 bits presented while first symbol held -> bit_ready low with bit_cnt=2 and pend_valid=1, bits not lost, second symbol follows immediately after 4-cycle hold.
REQ-033 GRAY_EN=0, bits 1,0,0 -> phase_offset=4.
REQ-034 rst pulsed one cycle during RUN with bit_cnt=1 -> next cycle phase_offset=IDLE_PHASE, underrun=0, active=0; a following 3-bit group 1,1,1 maps to 5.
REQ-035 bit_valid toggled randomly with scoreboard -> output phase sequence equals mapped input groups in order; sym_strobe count equals group count.
